// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the multi-port register bank.
// Imported by the clear sequencer and the top-level bank.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    localparam int unsigned DEF_DW  = 16;
    localparam int unsigned DEF_AW  = 4;
    localparam int unsigned DEF_NRD = 3;

endpackage

// File: rtl/reg_bank_clr_seq.sv
// Clear sequencer: sweeps every entry to zero after reset and on clr_req,
// and owns the registered ready flag that gates normal bank operation.
module reg_bank_clr_seq
    import reg_bank_pkg::*;
#(
    parameter int unsigned AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    clr_state_t    state;
    clr_state_t    state_nxt;
    logic [AW-1:0] clr_ptr;
    logic [AW-1:0] ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_INIT;
            clr_ptr <= '0;
            ready   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_ptr <= ptr_nxt;
            // ready tracks the state being entered, so it is high exactly in IDLE
            ready   <= (state_nxt == ST_IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = clr_ptr;
        unique case (state)
            ST_INIT, ST_CLEAR: begin
                if (clr_ptr == '1) begin
                    state_nxt = ST_IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt   = clr_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            default: begin
                state_nxt = ST_INIT;
                ptr_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        clr_we   = 1'b0;
        clr_addr = clr_ptr;
        if (state != ST_IDLE) begin
            clr_we = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_mp.sv
// Parametrised multi-port register bank with registered reads, write-first
// bypass, optional hard-wired zero entry and a hardware clear sweep.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned NRD      = DEF_NRD,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*DW-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DW-1:0]     wr_data,
    input  logic              clr_req,
    output logic              ready
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          wr_drop_zero;
    logic          user_we;
    logic          arr_we;
    logic [AW-1:0] arr_addr;
    logic [DW-1:0] arr_wdata;

    reg_bank_clr_seq #(
        .AW(AW)
    ) u_clr_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .ready   (ready),
        .clr_we  (clr_we),
        .clr_addr(clr_addr)
    );

    // A clear request in the same cycle pre-empts the user write.
    assign wr_drop_zero = ZERO_REG && (wr_addr == '0);
    assign user_we      = ready && wr_en && !clr_req && !wr_drop_zero;

    always_comb begin
        arr_we    = 1'b0;
        arr_addr  = wr_addr;
        arr_wdata = wr_data;
        if (clr_we) begin
            arr_we    = 1'b1;
            arr_addr  = clr_addr;
            arr_wdata = '0;
        end else if (user_we) begin
            arr_we    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_wdata;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] rd_nxt;
        logic [DW-1:0] rd_q;

        assign ra = rd_addr[g*AW +: AW];

        always_comb begin
            rd_nxt = '0;
            if (ready) begin
                if (ZERO_REG && (ra == '0)) begin
                    rd_nxt = '0;
                end else if (wr_en && (wr_addr == ra)) begin
                    rd_nxt = wr_data;
                end else begin
                    rd_nxt = mem[ra];
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_q <= '0;
            end else begin
                rd_q <= rd_nxt;
            end
        end

        assign rd_data[g*DW +: DW] = rd_q;
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Self-checking bench for reg_bank_mp: default build plus a 32-bit, 32-entry,
// two-port build without a zero register, both checked against array models.
module tb_reg_bank_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults (DW=16, AW=4, NRD=3, ZERO_REG=1)
    logic        a_rst_n = 1'b0;
    logic [11:0] a_rd_addr = '0;
    logic [47:0] a_rd_data;
    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = '0;
    logic [15:0] a_wr_data = '0;
    logic        a_clr_req = 1'b0;
    logic        a_ready;

    // Instance B: DW=32, AW=5, NRD=2, ZERO_REG=0
    logic        b_rst_n = 1'b0;
    logic [9:0]  b_rd_addr = '0;
    logic [63:0] b_rd_data;
    logic        b_wr_en = 1'b0;
    logic [4:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic        b_clr_req = 1'b0;
    logic        b_ready;

    reg_bank_mp u_dut_a (
        .clk    (clk),
        .rst_n  (a_rst_n),
        .rd_addr(a_rd_addr),
        .rd_data(a_rd_data),
        .wr_en  (a_wr_en),
        .wr_addr(a_wr_addr),
        .wr_data(a_wr_data),
        .clr_req(a_clr_req),
        .ready  (a_ready)
    );

    reg_bank_mp #(
        .DW      (32),
        .AW      (5),
        .NRD     (2),
        .ZERO_REG(1'b0)
    ) u_dut_b (
        .clk    (clk),
        .rst_n  (b_rst_n),
        .rd_addr(b_rd_addr),
        .rd_data(b_rd_data),
        .wr_en  (b_wr_en),
        .wr_addr(b_wr_addr),
        .wr_data(b_wr_data),
        .clr_req(b_clr_req),
        .ready  (b_ready)
    );

    logic [15:0] ma [16];
    bit          ma_ready = 1'b0;
    logic [31:0] mb [32];
    bit          mb_ready = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Value a port of A should show after the coming edge.
    function automatic logic [15:0] exp_a(input logic [3:0] a);
        if (!ma_ready)                        return 16'h0000;
        if (a == 4'd0)                        return 16'h0000;
        if (a_wr_en && a_wr_addr == a)        return a_wr_data;
        return ma[a];
    endfunction

    function automatic logic [31:0] exp_b(input logic [4:0] a);
        if (!mb_ready)                        return 32'h0;
        if (b_wr_en && b_wr_addr == a)        return b_wr_data;
        return mb[a];
    endfunction

    task automatic model_write_a;
        if (ma_ready && a_wr_en && !a_clr_req && a_wr_addr != 4'd0) ma[a_wr_addr] = a_wr_data;
    endtask

    task automatic model_write_b;
        if (mb_ready && b_wr_en && !b_clr_req) mb[b_wr_addr] = b_wr_data;
    endtask

    task automatic clear_model_a;
        for (int i = 0; i < 16; i++) ma[i] = 16'h0000;
    endtask

    task automatic clear_model_b;
        for (int i = 0; i < 32; i++) mb[i] = 32'h0;
    endtask

    task automatic test_reset;
        int n;
        tick;
        tick;
        checks++;
        if (a_ready !== 1'b0 || a_rd_data !== 48'h0) begin
            failures++;
            $display("FAIL reset_state ready=%b rd_data=%h required ready=0 rd_data=0", a_ready, a_rd_data);
        end
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        n = 0;
        while (a_ready !== 1'b1 && n < 40) begin
            tick;
            n++;
            checks++;
            if (a_rd_data !== 48'h0) begin
                failures++;
                $display("FAIL init_rd_zero edge=%0d rd_data=%h required 0", n, a_rd_data);
            end
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL init_sweep_len edges=%0d required 16", n);
        end
        clear_model_a();
        ma_ready = 1'b1;
        for (int e = 0; e < 16; e++) begin
            logic [15:0] ex [3];
            for (int p = 0; p < 3; p++) a_rd_addr[p*4 +: 4] = 4'((e + p) % 16);
            for (int p = 0; p < 3; p++) ex[p] = exp_a(a_rd_addr[p*4 +: 4]);
            tick;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (a_rd_data[p*16 +: 16] !== ex[p] || ex[p] !== 16'h0) begin
                    failures++;
                    $display("FAIL init_contents port=%0d addr=%0d got=%h required=0000", p, a_rd_addr[p*4 +: 4], a_rd_data[p*16 +: 16]);
                end
            end
        end
    endtask

    task automatic test_write_read;
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'hBEEF;
        a_rd_addr = {4'd2, 4'd3, 4'd4};
        model_write_a();
        tick;
        a_wr_en = 1'b0;
        a_rd_addr = {4'd9, 4'd5, 4'd1};
        tick;
        checks++;
        if (a_rd_data[31:16] !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_read port1 got=%h required=beef", a_rd_data[31:16]);
        end
    endtask

    task automatic test_bypass;
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 16'h1234;
        a_rd_addr = {4'd7, 4'd7, 4'd7};
        model_write_a();
        tick;
        a_wr_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if (a_rd_data[p*16 +: 16] !== 16'h1234) begin
                failures++;
                $display("FAIL bypass port=%0d got=%h required=1234", p, a_rd_data[p*16 +: 16]);
            end
        end
    endtask

    task automatic test_zero_reg;
        a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 16'hFFFF;
        a_rd_addr = {4'd0, 4'd7, 4'd0};
        model_write_a();
        tick;
        a_wr_en = 1'b0;
        checks++;
        if (a_rd_data[15:0] !== 16'h0 || a_rd_data[47:32] !== 16'h0 || a_rd_data[31:16] !== 16'h1234) begin
            failures++;
            $display("FAIL zero_bypass rd_data=%h required 0000_1234_0000", a_rd_data);
        end
        tick;
        checks++;
        if (a_rd_data[15:0] !== 16'h0 || a_rd_data[47:32] !== 16'h0) begin
            failures++;
            $display("FAIL zero_stored rd_data=%h required ports 0,2 = 0000", a_rd_data);
        end
    endtask

    task automatic test_random;
        for (int c = 0; c < 300; c++) begin
            logic [15:0] ex [3];
            a_wr_en   = 1'($urandom_range(0, 1));
            a_wr_addr = 4'($urandom);
            a_wr_data = 16'($urandom);
            a_rd_addr = 12'($urandom);
            if ($urandom_range(0, 3) == 0) a_rd_addr[4 +: 4] = a_wr_addr;
            for (int p = 0; p < 3; p++) ex[p] = exp_a(a_rd_addr[p*4 +: 4]);
            model_write_a();
            tick;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (a_rd_data[p*16 +: 16] !== ex[p]) begin
                    failures++;
                    $display("FAIL random cyc=%0d port=%0d got=%h required=%h", c, p, a_rd_data[p*16 +: 16], ex[p]);
                end
            end
        end
        a_wr_en = 1'b0;
    endtask

    task automatic test_clear_with_write;
        int n;
        for (int i = 1; i < 16; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 16'(i * 16'h0101);
            model_write_a();
            tick;
        end
        a_wr_en = 1'b0;
        a_rd_addr = {4'd0, 4'd0, 4'd3};
        tick;
        checks++;
        if (a_rd_data[15:0] !== 16'h0303) begin
            failures++;
            $display("FAIL fill_check got=%h required=0303", a_rd_data[15:0]);
        end
        a_clr_req = 1'b1; a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 16'hAAAA;
        tick;
        a_clr_req = 1'b0;
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL clr_ready_drop ready=%b required 0", a_ready);
        end
        ma_ready = 1'b0;
        clear_model_a();
        a_wr_data = 16'h5555;
        n = 0;
        while (a_ready !== 1'b1 && n < 64) begin
            tick;
            n++;
            checks++;
            if (a_rd_data !== 48'h0) begin
                failures++;
                $display("FAIL clr_rd_zero edge=%0d rd_data=%h required 0", n, a_rd_data);
            end
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL clr_sweep_len edges=%0d required 16", n);
        end
        a_wr_en = 1'b0;
        ma_ready = 1'b1;
        for (int e = 0; e < 16; e++) begin
            a_rd_addr = {4'(e), 4'(e), 4'(e)};
            tick;
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (a_rd_data[p*16 +: 16] !== ma[e]) begin
                    failures++;
                    $display("FAIL clr_contents port=%0d addr=%0d got=%h required=%h", p, e, a_rd_data[p*16 +: 16], ma[e]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_clear;
        int n;
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'h0505;
        model_write_a();
        tick;
        a_wr_en = 1'b0;
        a_rd_addr = {4'd5, 4'd5, 4'd5};
        tick;
        checks++;
        if (a_rd_data !== {3{16'h0505}}) begin
            failures++;
            $display("FAIL pre_reset_read got=%h required=050505050505", a_rd_data);
        end
        a_rst_n = 1'b0;
        #1;
        checks++;
        if (a_rd_data !== 48'h0 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL async_reset rd_data=%h ready=%b required 0/0", a_rd_data, a_ready);
        end
        tick;
        a_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) tick;
        for (int i = 1; i < 16; i++) begin
            a_wr_en = 1'b1; a_wr_addr = 4'(i); a_wr_data = 16'hC000 | 16'(i);
            tick;
        end
        a_wr_en = 1'b0;
        a_clr_req = 1'b1;
        tick;
        a_clr_req = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        a_rst_n = 1'b0;
        #1;
        checks++;
        if (a_rd_data !== 48'h0 || a_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_clear rd_data=%h ready=%b required 0/0", a_rd_data, a_ready);
        end
        tick;
        a_rst_n = 1'b1;
        n = 0;
        while (a_ready !== 1'b1 && n < 40) begin
            tick;
            n++;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL reinit_sweep_len edges=%0d required 16", n);
        end
        clear_model_a();
        for (int e = 0; e < 16; e++) begin
            a_rd_addr = {4'(e), 4'(15 - e), 4'(e)};
            tick;
            checks++;
            if (a_rd_data !== 48'h0) begin
                failures++;
                $display("FAIL reinit_contents addr=%0d rd_data=%h required 0", e, a_rd_data);
            end
        end
    endtask

    task automatic test_p2_reset;
        int n;
        b_rst_n = 1'b0;
        tick;
        checks++;
        if (b_ready !== 1'b0 || b_rd_data !== 64'h0) begin
            failures++;
            $display("FAIL p2_reset ready=%b rd_data=%h required 0/0", b_ready, b_rd_data);
        end
        b_rst_n = 1'b1;
        n = 0;
        while (b_ready !== 1'b1 && n < 80) begin
            tick;
            n++;
        end
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL p2_sweep_len edges=%0d required 32", n);
        end
        clear_model_b();
        mb_ready = 1'b1;
    endtask

    task automatic test_p2_bypass;
        logic [31:0] ex [2];
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'hDEADBEEF;
        b_rd_addr = {5'd0, 5'd0};
        model_write_b();
        tick;
        b_wr_en = 1'b0;
        checks++;
        if (b_rd_data !== {2{32'hDEADBEEF}}) begin
            failures++;
            $display("FAIL p2_bypass_e0 got=%h required=deadbeefdeadbeef", b_rd_data);
        end
        tick;
        checks++;
        if (b_rd_data !== {2{32'hDEADBEEF}}) begin
            failures++;
            $display("FAIL p2_stored_e0 got=%h required=deadbeefdeadbeef", b_rd_data);
        end
        for (int c = 0; c < 100; c++) begin
            b_wr_en   = 1'($urandom_range(0, 1));
            b_wr_addr = 5'($urandom);
            b_wr_data = $urandom;
            b_rd_addr = 10'($urandom);
            if ($urandom_range(0, 2) == 0) b_rd_addr = {b_wr_addr, b_wr_addr};
            for (int p = 0; p < 2; p++) ex[p] = exp_b(b_rd_addr[p*5 +: 5]);
            model_write_b();
            tick;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (b_rd_data[p*32 +: 32] !== ex[p]) begin
                    failures++;
                    $display("FAIL p2_random cyc=%0d port=%0d got=%h required=%h", c, p, b_rd_data[p*32 +: 32], ex[p]);
                end
            end
        end
        b_wr_en = 1'b0;
    endtask

    task automatic test_p2_clear;
        int n;
        for (int i = 0; i < 32; i++) begin
            b_wr_en = 1'b1; b_wr_addr = 5'(i); b_wr_data = 32'(i) * 32'h01010101 + 32'h11;
            model_write_b();
            tick;
        end
        b_clr_req = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'hAAAAAAAA;
        tick;
        b_clr_req = 1'b0;
        b_wr_en = 1'b0;
        mb_ready = 1'b0;
        clear_model_b();
        n = 1;
        while (b_ready !== 1'b1 && n < 100) begin
            tick;
            n++;
        end
        checks++;
        if (n != 33) begin
            failures++;
            $display("FAIL p2_clr_len edges=%0d required 33", n);
        end
        mb_ready = 1'b1;
        for (int e = 0; e < 32; e++) begin
            b_rd_addr = {5'(31 - e), 5'(e)};
            tick;
            checks++;
            if (b_rd_data !== 64'h0) begin
                failures++;
                $display("FAIL p2_clr_contents addr=%0d got=%h required 0", e, b_rd_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_random();
        test_clear_with_write();
        test_reset_mid_clear();
        test_p2_reset();
        test_p2_bypass();
        test_p2_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
